// File: rtl/radiant_event_hdr_engine.sv
// radiant_event_hdr_engine: PPS/clock/event counters with resync, 8-dword event header FIFO and drop accounting
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   pps_i                    one-cycle PPS pulse (already in clk_i domain)
//   sync_req_i               arm a counter resync at the next pps_i
//   sync_armed_o             resync is armed
//   trig_i, trig_info_i      per-source trigger pulses and info word captured with an event
//   fifo_clear_i             flush header FIFO, read index and drop accounting
//   hdr_valid_o, hdr_dat_o   show-ahead header dword stream
//   hdr_last_o, hdr_rd_i     dword 7 marker and per-dword consume strobe
//   fifo_full_o, dropped_o   FIFO full and saturating drop count
//   pps_count_o              low 32 bits of the seconds counter
module radiant_event_hdr_engine #(
    parameter int          NUM_TRIG   = 4,
    parameter int          CNT_WIDTH  = 48,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] IDENT      = 32'h52444531
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pps_i,
    input  logic                sync_req_i,
    output logic                sync_armed_o,
    input  logic [NUM_TRIG-1:0] trig_i,
    input  logic [31:0]         trig_info_i,
    input  logic                fifo_clear_i,
    output logic                hdr_valid_o,
    output logic [31:0]         hdr_dat_o,
    output logic                hdr_last_o,
    input  logic                hdr_rd_i,
    output logic                fifo_full_o,
    output logic [15:0]         dropped_o,
    output logic [31:0]         pps_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [CNT_WIDTH-1:0] clk_cnt_q, clk_cnt_d, sec_cnt_q, sec_cnt_d, evt_cnt_q, evt_cnt_d;
    logic [31:0]          last_pps_q, last_pps_d, lastlast_pps_q, lastlast_pps_d;
    logic                 evt_ref_q, evt_ref_d, sec_ref_q, sec_ref_d, clk_ref_q, clk_ref_d;
    logic                 armed_q, armed_d, drop_flag_q, drop_flag_d;
    logic [15:0]          dropped_q, dropped_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]           idx_q, idx_d;
    // dwords 1..7 of each record; dword 0 is the constant IDENT and is not stored
    logic [223:0]         mem_q [FIFO_DEPTH];
    logic [223:0]         wr_data;
    logic [255:0]         rec;
    logic [31:0]          status;
    logic                 ev, valid, full, wr_en, drop, sync_pps, rd_adv, pop;

    always_comb begin
        ev       = |trig_i;
        valid    = wr_ptr_q != rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_en    = ev && !full && !fifo_clear_i;
        drop     = ev && full && !fifo_clear_i;
        sync_pps = pps_i && armed_q;
        rd_adv   = hdr_rd_i && valid;
        pop      = rd_adv && idx_q == 3'd7;
        // roll bits compare counter bit 32 against its value at the last stored header
        status                = '0;
        status[8 +: NUM_TRIG] = trig_i;
        status[3:0]           = {drop_flag_q, clk_cnt_q[32] ^ clk_ref_q,
                                 sec_cnt_q[32] ^ sec_ref_q, evt_cnt_q[32] ^ evt_ref_q};
        wr_data = {lastlast_pps_q, last_pps_q, status, trig_info_i,
                   clk_cnt_q[31:0], evt_cnt_q[31:0], sec_cnt_q[31:0]};
    end

    always_comb begin
        clk_cnt_d      = sync_pps ? '0 : clk_cnt_q + CNT_WIDTH'(1);
        sec_cnt_d      = sync_pps ? '0 : sec_cnt_q + CNT_WIDTH'(pps_i);
        evt_cnt_d      = sync_pps ? '0 : evt_cnt_q + CNT_WIDTH'(ev);
        last_pps_d     = sync_pps ? '0 : pps_i ? clk_cnt_q[31:0] : last_pps_q;
        lastlast_pps_d = sync_pps ? '0 : pps_i ? last_pps_q : lastlast_pps_q;
        evt_ref_d      = sync_pps ? 1'b0 : wr_en ? evt_cnt_q[32] : evt_ref_q;
        sec_ref_d      = sync_pps ? 1'b0 : wr_en ? sec_cnt_q[32] : sec_ref_q;
        clk_ref_d      = sync_pps ? 1'b0 : wr_en ? clk_cnt_q[32] : clk_ref_q;
        // a request coinciding with the resync PPS re-arms
        armed_d        = sync_req_i | (armed_q & ~pps_i);
        drop_flag_d    = (fifo_clear_i || wr_en) ? 1'b0 : drop ? 1'b1 : drop_flag_q;
        dropped_d      = fifo_clear_i ? '0 :
                         (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
        wr_ptr_d       = fifo_clear_i ? '0 : wr_ptr_q + PW'(wr_en);
        rd_ptr_d       = fifo_clear_i ? '0 : rd_ptr_q + PW'(pop);
        idx_d          = fifo_clear_i ? '0 : rd_adv ? idx_q + 3'd1 : idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            clk_cnt_q      <= '0;
            sec_cnt_q      <= '0;
            evt_cnt_q      <= '0;
            last_pps_q     <= '0;
            lastlast_pps_q <= '0;
            evt_ref_q      <= 1'b0;
            sec_ref_q      <= 1'b0;
            clk_ref_q      <= 1'b0;
            armed_q        <= 1'b0;
            drop_flag_q    <= 1'b0;
            dropped_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            idx_q          <= '0;
        end else begin
            clk_cnt_q      <= clk_cnt_d;
            sec_cnt_q      <= sec_cnt_d;
            evt_cnt_q      <= evt_cnt_d;
            last_pps_q     <= last_pps_d;
            lastlast_pps_q <= lastlast_pps_d;
            evt_ref_q      <= evt_ref_d;
            sec_ref_q      <= sec_ref_d;
            clk_ref_q      <= clk_ref_d;
            armed_q        <= armed_d;
            drop_flag_q    <= drop_flag_d;
            dropped_q      <= dropped_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            idx_q          <= idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rec          = {mem_q[rd_ptr_q[AW-1:0]], IDENT};
    assign hdr_valid_o  = valid;
    assign hdr_dat_o    = valid ? rec[{idx_q, 5'b0} +: 32] : '0;
    assign hdr_last_o   = valid && idx_q == 3'd7;
    assign fifo_full_o  = full;
    assign dropped_o    = dropped_q;
    assign sync_armed_o = armed_q;
    assign pps_count_o  = sec_cnt_q[31:0];

endmodule
